// File: rtl/dm_pkg.sv
// Shared types and constants for the PE data-memory row loader.
//
// A row is ROW_W bits wide and is assembled from BEATS stream beats of BEAT_W bits.
// Beat 0 lands in the least significant lane. The memory has 2**ADDR_W rows.
// BEATS is derived from ROW_W and BEAT_W and cannot be overridden.
package dm_pkg;

  localparam int unsigned BEAT_W = 32;
  localparam int unsigned ROW_W  = 512;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned BEATS  = ROW_W / BEAT_W;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned ROWS   = 2 ** ADDR_W;

  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [ADDR_W-1:0] addr_t;
  // One bit wider than addr_t so a burst can cover every row (1..ROWS).
  typedef logic [ADDR_W:0]   count_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } loader_state_e;

  localparam cnt_t LAST_LANE = cnt_t'(BEATS - 1);

  // A burst length is legal when it names at least one row and no more than the memory holds.
  function automatic logic count_ok(input count_t c);
    return (c != '0) && (c <= count_t'(ROWS));
  endfunction

endpackage

// File: rtl/dm_row_packer.sv
// Beat counter plus lane-insert row buffer for the data-memory row loader.
//
// Ports:
//   CLK, MEMRST   clock, asynchronous active-low reset
//   clear_i       zero the row buffer and the beat counter (start of a burst)
//   clear_cnt_i   zero only the beat counter (start of the next row)
//   load_i        write data_i into the lane selected by the beat counter, then advance it
//   pad_i         with load_i, also zero every lane above the loaded one
//   data_i        beat to insert
//   cnt_o         index of the lane the next beat goes to
//   row_o         registered row buffer
module dm_row_packer
  import dm_pkg::*;
(
  input  logic  CLK,
  input  logic  MEMRST,
  input  logic  clear_i,
  input  logic  clear_cnt_i,
  input  logic  load_i,
  input  logic  pad_i,
  input  beat_t data_i,
  output cnt_t  cnt_o,
  output row_t  row_o
);

  cnt_t cnt_q, cnt_d;
  row_t row_q, row_d;

  always_comb begin
    cnt_d = cnt_q;
    row_d = row_q;
    if (clear_i) begin
      cnt_d = '0;
      row_d = '0;
    end else begin
      if (clear_cnt_i) begin
        cnt_d = '0;
      end
      if (load_i) begin
        for (int unsigned i = 0; i < BEATS; i++) begin
          if (cnt_t'(i) == cnt_q) begin
            row_d[i*BEAT_W +: BEAT_W] = data_i;
          end else if (pad_i && (cnt_t'(i) > cnt_q)) begin
            row_d[i*BEAT_W +: BEAT_W] = '0;
          end
        end
        // Wraps from the last lane back to 0, ready for the next row.
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge MEMRST) begin
    if (!MEMRST) begin
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

  assign cnt_o = cnt_q;
  assign row_o = row_q;

endmodule

// File: rtl/dm_row_loader.sv
// Write-side initiator for the 32 x 512-bit PE data memory.
//
// Packs a 32-bit valid/ready beat stream into 512-bit rows (16 beats per row) and writes each
// completed row to consecutive addresses, wrapping from the top row back to row 0. One row
// takes 17 cycles with s_valid held high: 16 FILL cycles and one WRITE cycle.
//
// Ports:
//   CLK, MEMRST        clock, asynchronous active-low reset (shared with the memory)
//   start_i            begins a burst; only looked at while idle
//   start_addr_i       first row address of the burst
//   row_count_i        rows in the burst, 1..32; anything else pulses err_o
//   s_data_i/s_valid_i/s_last_i/s_ready_o   beat stream; s_last_i marks the final beat
//   mem_addr_o/mem_data_o/mem_cs_o/mem_we_o memory write port (InAddress/DataIn/CS/WE)
//   busy_o             burst in progress
//   done_o             one-cycle pulse when a burst completes
//   err_o              one-cycle pulse on a protocol error
//
// Build option DM_LOADER_PARTIAL_EN: an early s_last zero-pads the current row, writes it and
// ends the burst. Without it an early s_last drops the partial row, pulses err_o and ends.
module dm_row_loader
  import dm_pkg::*;
(
  input  logic   CLK,
  input  logic   MEMRST,
  input  logic   start_i,
  input  addr_t  start_addr_i,
  input  count_t row_count_i,
  input  beat_t  s_data_i,
  input  logic   s_valid_i,
  input  logic   s_last_i,
  output logic   s_ready_o,
  output addr_t  mem_addr_o,
  output row_t   mem_data_o,
  output logic   mem_cs_o,
  output logic   mem_we_o,
  output logic   busy_o,
  output logic   done_o,
  output logic   err_o
);

  loader_state_e state_q, state_d;
  addr_t         addr_q, addr_d;
  count_t        rows_q, rows_d;
  logic          err_q, err_d;

  logic pk_clear, pk_clear_cnt, pk_load, pk_pad;
  cnt_t beat_cnt;
  row_t row;

  logic beat_acc;
  logic final_beat;
  logic early_last;

  dm_row_packer u_packer (
    .CLK         (CLK),
    .MEMRST      (MEMRST),
    .clear_i     (pk_clear),
    .clear_cnt_i (pk_clear_cnt),
    .load_i      (pk_load),
    .pad_i       (pk_pad),
    .data_i      (s_data_i),
    .cnt_o       (beat_cnt),
    .row_o       (row)
  );

  assign beat_acc   = (state_q == FILL) && s_valid_i;
  // The only beat allowed to carry s_last: the last lane of the last row.
  assign final_beat = (beat_cnt == LAST_LANE) && (rows_q == count_t'(1));
  assign early_last = s_last_i && !final_beat;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rows_d       = rows_q;
    err_d        = 1'b0;
    pk_clear     = 1'b0;
    pk_clear_cnt = 1'b0;
    pk_load      = 1'b0;
    pk_pad       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_ok(row_count_i)) begin
            addr_d   = start_addr_i;
            rows_d   = row_count_i;
            pk_clear = 1'b1;
            state_d  = FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (beat_acc) begin
          pk_load = 1'b1;
          if (early_last) begin
`ifdef DM_LOADER_PARTIAL_EN
            // Pad and write this row, and make it the last one of the burst.
            pk_pad  = 1'b1;
            rows_d  = count_t'(1);
            state_d = WRITE;
`else
            err_d   = 1'b1;
            state_d = DONE;
`endif
          end else if (beat_cnt == LAST_LANE) begin
            err_d   = final_beat && !s_last_i;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d       = addr_q + addr_t'(1);
        rows_d       = rows_q - count_t'(1);
        pk_clear_cnt = 1'b1;
        state_d      = (rows_q == count_t'(1)) ? DONE : FILL;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge MEMRST) begin
    if (!MEMRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rows_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rows_q  <= rows_d;
      err_q   <= err_d;
    end
  end

  // Every output below is either a register or a decode of the state register.
  assign s_ready_o  = (state_q == FILL);
  assign mem_cs_o   = (state_q == WRITE);
  assign mem_we_o   = (state_q == WRITE);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign err_o      = err_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = row;

endmodule

// File: tb/tb_dm_row_loader.sv
// Self-checking bench for dm_row_loader: directed and randomized bursts compared against a
// row-level reference model of the write stream, error pulses and done pulses.
module tb_dm_row_loader;

`ifdef DM_LOADER_PARTIAL_EN
  localparam bit PARTIAL = 1'b1;
`else
  localparam bit PARTIAL = 1'b0;
`endif

  logic         CLK;
  logic         MEMRST;
  logic         start;
  logic [4:0]   start_addr;
  logic [5:0]   row_count;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [4:0]   mem_addr;
  logic [511:0] mem_data;
  logic         mem_cs;
  logic         mem_we;
  logic         busy;
  logic         done;
  logic         err;

  dm_row_loader dut (
    .CLK          (CLK),
    .MEMRST       (MEMRST),
    .start_i      (start),
    .start_addr_i (start_addr),
    .row_count_i  (row_count),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_last_i     (s_last),
    .s_ready_o    (s_ready),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_data),
    .mem_cs_o     (mem_cs),
    .mem_we_o     (mem_we),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, written only by the monitor process.
  int           cyc      = 0;
  int           err_cnt  = 0;
  int           done_cnt = 0;
  int           busy_cnt = 0;
  int           bad_wr   = 0;
  int           done_cyc = 0;
  int           hs_cyc   = 0;
  logic [4:0]   wr_addr [$];
  logic [511:0] wr_data [$];
  int           wr_cyc  [$];

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (mem_cs || mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
      wr_cyc.push_back(cyc);
      if (!(mem_cs && mem_we) || s_ready) bad_wr <= bad_wr + 1;
    end
    if (err) err_cnt <= err_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (s_valid && s_ready) hs_cyc <= cyc;
  end

  // Stimulus beats and reference-model expectations.
  logic [31:0]  beats    [$];
  logic [4:0]   exp_addr [$];
  logic [511:0] exp_row  [$];
  int           exp_err;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Row-level model: beats fill rows 16 at a time, rows go to successive addresses mod 32.
  task automatic model(input int sa, input int rc, input int n, input int last_at);
    logic [511:0] r;
    int fb, lane, rowi;
    exp_addr.delete();
    exp_row.delete();
    exp_err = 0;
    r  = '0;
    fb = rc * 16 - 1;
    for (int i = 0; i < n; i++) begin
      lane = i % 16;
      rowi = i / 16;
      if (lane == 0) r = '0;
      r[lane*32 +: 32] = beats[i];
      if (i == last_at && i != fb) begin
        if (PARTIAL) begin
          exp_addr.push_back(5'((sa + rowi) % 32));
          exp_row.push_back(r);
        end else begin
          exp_err++;
        end
        break;
      end
      if (lane == 15) begin
        exp_addr.push_back(5'((sa + rowi) % 32));
        exp_row.push_back(r);
        if (i == fb) begin
          if (last_at != i) exp_err++;
          break;
        end
      end
    end
  endtask

  task automatic pulse_start(input int sa, input int rc);
    start      = 1'b1;
    start_addr = 5'(sa);
    row_count  = 6'(rc);
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input int last_at, input bit gap, input bit inj);
    logic hs;
    int   t;
    for (int i = 0; i < n; i++) begin
      if (gap && ($urandom_range(1, 0) == 1)) begin
        s_valid = 1'b0;
        @(posedge CLK); #1;
      end
      s_valid = 1'b1;
      s_data  = beats[i];
      s_last  = (i == last_at);
      if (inj && i == 5) begin
        start      = 1'b1;
        start_addr = 5'd20;
        row_count  = 6'd1;
      end
      hs = 1'b0;
      t  = 0;
      while (!hs && t < 100) begin
        @(negedge CLK);
        hs = s_ready;
        @(posedge CLK); #1;
        start = 1'b0;
        t++;
      end
      if (!hs) begin
        check($sformatf("handshake_beat%0d", i), hs, 1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200 && busy; t++) begin
      @(posedge CLK); #1;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic run_burst(input int sa, input int rc, input int n, input int last_at,
                           input bit gap, input bit inj, input string tag);
    int wb, eb, db, bb;
    model(sa, rc, n, last_at);
    wb = wr_addr.size();
    eb = err_cnt;
    db = done_cnt;
    bb = bad_wr;
    pulse_start(sa, rc);
    send_beats(n, last_at, gap, inj);
    wait_idle();
    check({tag, "_nwrites"}, wr_addr.size() - wb, exp_addr.size());
    for (int k = 0; k < exp_addr.size() && (wb + k) < wr_addr.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), wr_addr[wb+k], exp_addr[k]);
      check($sformatf("%s_data%0d", tag, k), wr_data[wb+k], exp_row[k]);
    end
    check({tag, "_err"}, err_cnt - eb, exp_err);
    check({tag, "_done"}, done_cnt - db, 1);
    check({tag, "_wrcycle_ctl"}, bad_wr - bb, 0);
  endtask

  task automatic fill_seq(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back(32'(i));
  endtask

  task automatic fill_rand(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back($urandom());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_cs"}, mem_cs, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_data"}, mem_data, 0);
  endtask

  initial begin
    int wb, eb, bb, rc, sa, lst;
    logic [511:0] ramp;

    MEMRST     = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    row_count  = '0;
    s_data     = '0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    #2 MEMRST = 1'b0;
    #10;
    check_reset_outputs("reset");
    @(posedge CLK); #3 MEMRST = 1'b1;
    @(posedge CLK); #1;

    // Single row, lane k = k.
    fill_seq(16);
    wb = wr_addr.size();
    run_burst(3, 1, 16, 15, 1'b0, 1'b0, "single");
    for (int k = 0; k < 16; k++) ramp[k*32 +: 32] = 32'(k);
    if (wr_data.size() > wb) check("single_ramp", wr_data[wb], ramp);
    if (wr_cyc.size() > wb) check("single_wr_lat", wr_cyc[wb] - hs_cyc, 1);
    check("single_done_lat", done_cyc - hs_cyc, 2);

    // Address wrap with s_valid held high: 17 cycles per row.
    fill_rand(48);
    wb = wr_addr.size();
    run_burst(30, 3, 48, 47, 1'b0, 1'b0, "wrap");
    if (wr_cyc.size() >= wb + 3) begin
      check("wrap_gap0", wr_cyc[wb+1] - wr_cyc[wb], 17);
      check("wrap_gap1", wr_cyc[wb+2] - wr_cyc[wb+1], 17);
    end

    // Backpressure gaps give the same row as the gap-free case.
    fill_seq(16);
    run_burst(7, 1, 16, 15, 1'b1, 1'b0, "gaps");

    // Randomized bursts, sometimes without s_last on the final beat.
    for (int r = 0; r < 4; r++) begin
      rc  = $urandom_range(3, 1);
      sa  = $urandom_range(31, 0);
      lst = ($urandom_range(3, 0) == 0) ? -1 : rc * 16 - 1;
      fill_rand(rc * 16);
      run_burst(sa, rc, rc * 16, lst, 1'b1, 1'b0, $sformatf("rand%0d", r));
    end

    // Illegal burst lengths.
    eb = err_cnt;
    bb = busy_cnt;
    pulse_start(4, 0);
    repeat (3) begin @(posedge CLK); #1; end
    check("rc0_err", err_cnt - eb, 1);
    check("rc0_busy", busy_cnt - bb, 0);
    eb = err_cnt;
    bb = busy_cnt;
    pulse_start(4, 33);
    repeat (3) begin @(posedge CLK); #1; end
    check("rc33_err", err_cnt - eb, 1);
    check("rc33_busy", busy_cnt - bb, 0);

    // Start while busy is ignored.
    fill_rand(16);
    run_burst(12, 1, 16, 15, 1'b0, 1'b1, "startbusy");
    bb = busy_cnt;
    repeat (3) begin @(posedge CLK); #1; end
    check("startbusy_quiet", busy_cnt - bb, 0);

    // Missing s_last on the final beat.
    fill_rand(32);
    run_burst(17, 2, 32, -1, 1'b0, 1'b0, "nolast");

    // Early s_last on beat 4 of row 0 of a two-row burst.
    fill_rand(5);
    run_burst(9, 2, 5, 4, 1'b0, 1'b0, "early");

    // Reset during FILL of row 1.
    fill_rand(19);
    wb = wr_addr.size();
    pulse_start(5, 2);
    send_beats(19, -1, 1'b0, 1'b0);
    check("rst_mid_prewrites", wr_addr.size() - wb, 1);
    MEMRST = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    #2 MEMRST = 1'b1;
    @(posedge CLK); #1;
    fill_rand(16);
    run_burst(28, 1, 16, 15, 1'b1, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_row_loader.md
Name: dm_row_loader

Overview:
- Write-side initiator for the 32 x 512-bit PE data memory.
- Accepts a 32-bit valid/ready beat stream and packs 16 beats into one 512-bit row.
- Writes each completed row to consecutive memory addresses through the CS/WE/InAddress/DataIn write port.
- Sits between the host/DMA stream and the data memory. Loads operand vectors before PE execution.

Parameters:
- BEAT_W, 32, stream beat width in bits.
- ROW_W, 512, memory row width in bits. Must be a multiple of BEAT_W.
- ADDR_W, 5, memory address width (32 rows).
- BEATS, ROW_W/BEAT_W = 16, beats per row (derived, not overridable).

Ports:
- CLK  in  1  clock
- MEMRST  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that begins a burst; sampled only in IDLE
- start_addr  in  ADDR_W  first row address of the burst
- row_count  in  ADDR_W+1  rows in the burst, 1..32
- s_data  in  BEAT_W  stream beat
- s_valid  in  1  beat valid
- s_last  in  1  final beat of the burst
- s_ready  out  1  loader can accept a beat
- mem_addr  out  ADDR_W  to memory InAddress
- mem_data  out  ROW_W  to memory DataIn
- mem_cs  out  1  to memory CS
- mem_we  out  1  to memory WE
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when the burst completes
- err  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset (MEMRST=0, async) sets:
  - state=IDLE
  - s_ready=0, mem_cs=0, mem_we=0, busy=0, done=0, err=0
  - mem_addr=0, mem_data=0
  - beat counter=0, rows remaining=0
- FSM states are IDLE, FILL, WRITE, DONE.
- IDLE:
  - On start with row_count in 1..32: latch start_addr and row_count, clear the row buffer, go to FILL.
  - On start with row_count=0 or row_count>32: pulse err, stay in IDLE.
- FILL:
  - s_ready=1.
  - A beat is accepted when s_valid && s_ready.
  - Beat k (0..15) goes to row bits [32k+31:32k]. Beat 0 is the LSB lane.
  - Go to WRITE after accepting beat 15.
- WRITE (exactly one cycle):
  - s_ready=0, mem_cs=1, mem_we=1.
  - mem_addr holds the current row address. mem_data holds the packed row.
  - The memory captures the row on this cycle's rising CLK edge.
  - Then increment the address (31 wraps to 0) and decrement rows remaining.
  - If rows remaining becomes 0, go to DONE. Otherwise clear the beat counter and go to FILL.
- DONE: pulse done for one cycle, go to IDLE.
- Throughput: 17 cycles per row when s_valid is held high. The row buffer is single, so filling and writing do not overlap.
- mem_cs and mem_we are 0 in every state except WRITE.
- mem_data and mem_addr are registered outputs.
- busy=1 in FILL, WRITE and DONE.
- start while busy is ignored. No err is raised.
- s_last rules:
  - s_last must coincide with beat 15 of the final row.
  - s_last absent on that beat: pulse err. The burst still completes normally.
  - s_last early (on any other beat): behaviour depends on DM_LOADER_PARTIAL_EN (see below).
- Reset mid-burst aborts immediately and returns to the reset values above. The memory shares MEMRST and is cleared as well.

Optional Feature:
- Macro: DM_LOADER_PARTIAL_EN.
- Defined:
  - s_last on beat k<15 of the final row zero-fills lanes k+1..15.
  - The loader then goes directly to WRITE and writes the padded row.
  - Then DONE. No err is raised.
  - s_last before the final row ends the burst the same way: the padded row is written, remaining rows are skipped, done pulses.
- Undefined:
  - An early s_last pulses err in the cycle after the beat is accepted.
  - The loader drops the partial row (no write), then goes to DONE and pulses done.

Decomposition:
- Package dm_pkg:
  - ROW_W, BEAT_W, ADDR_W, BEATS
  - typedef row_t (logic [ROW_W-1:0])
  - typedef addr_t
  - enum loader_state_e {IDLE, FILL, WRITE, DONE}
- One sub-module, dm_row_packer: the beat counter plus lane-insert row buffer, with clear, load and zero-pad controls. The FSM stays in dm_row_loader.

Test Plan:
- Single row: start_addr=3, row_count=1, beats 0x00000000..0x0000000F, s_last on beat 15 -> exactly one cycle of mem_cs=mem_we=1 with mem_addr=3 and mem_data lane k = k; done pulses 2 cycles later; memory row 3 reads back the same value.
- Wrap: start_addr=30, row_count=3, s_valid held high -> writes to addresses 30, 31, 0 spaced 17 cycles apart; s_ready=0 on each WRITE cycle.
- Backpressure gaps: s_valid toggling 1/0 -> only handshaken beats are packed; the row is identical to the no-gap case.
- Errors: row_count=0 -> err pulse, busy stays 0. row_count=33 -> err pulse. start while busy -> ignored, no err. Missing s_last on the final beat -> err pulse, done still pulses.
- Early s_last on beat 4 of row 0, row_count=2 -> with DM_LOADER_PARTIAL_EN: write to start_addr with lanes 5..15 = 0, then done. Without it: no write, err pulse, done.
- MEMRST asserted during FILL of row 1 -> all outputs at reset values immediately; after release, a fresh start succeeds.
